axi_stream_extract_header: RTL and testbench

Receive-side counterpart of the header inserter. It strips a leading header of hdr_len bytes (1..DATA_BYTE_WD) from each AXI-Stream packet. The header is presented on a separate header channel, and the remaining payload is re-aligned into full, MSB-first beats. It sits between the link receive path and the payload consumer.

---
 rtl/axi_stream_extract_header.sv | 155 +++++++++++++++
 tb/tb_axi_stream_extract_header.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_extract_header.sv
// Strips a 1..DATA_BYTE_WD byte header from each AXI-Stream packet onto a side
// channel and re-packs the remaining payload into full MSB-first beats.
module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int HDR_LEN_WD   = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic [HDR_LEN_WD-1:0]   hdr_len,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      header_out,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header
);

  localparam int CW = HDR_LEN_WD + 1;
  typedef logic [CW-1:0]           cnt_t;
  typedef logic [DATA_BYTE_WD-1:0] keep_t;
  typedef logic [DATA_WD-1:0]      data_t;
  localparam cnt_t FULL = cnt_t'(DATA_BYTE_WD);

  typedef enum logic [1:0] {FIRST, BODY, FLUSH} state_t;

  function automatic cnt_t popcnt(input keep_t k);
    cnt_t c;
    c = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) c = c + cnt_t'(k[i]);
    return c;
  endfunction

  function automatic keep_t msb_mask(input cnt_t n);
    keep_t ones;
    ones = '1;
    return ~(ones >> n);
  endfunction

  function automatic keep_t lsb_mask(input cnt_t n);
    keep_t ones;
    ones = '1;
    return ~(ones << n);
  endfunction

  function automatic data_t byte_mask(input keep_t k);
    data_t m;
    m = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_t state_q;
  data_t  res_q;
  cnt_t   res_cnt_q;
  logic   valid_out_q, last_out_q, valid_header_q;
  data_t  data_out_q, header_q;
  keep_t  keep_out_q, keep_header_q;

  cnt_t  h, n_in, hn, f_rcnt, b_total, b_rcnt;
  keep_t f_hkeep, b_keep;
  data_t f_hdata, f_res, b_data, b_res;
  logic  b_fits, out_free, accept;

  // Residual bytes are kept MSB-aligned so each beat is {residual, head of data_in}.
  always_comb begin
    h = cnt_t'(hdr_len);
    if (h == '0 || h > FULL) h = FULL;
    n_in    = last_in ? popcnt(keep_in) : FULL;
    hn      = (n_in < h) ? n_in : h;
    f_hkeep = lsb_mask(hn);
    f_hdata = (data_in >> {FULL - hn, 3'b000}) & byte_mask(f_hkeep);
    f_rcnt  = (n_in > h) ? n_in - h : '0;
    f_res   = (data_in << {h, 3'b000}) & byte_mask(msb_mask(f_rcnt));
    b_total = res_cnt_q + n_in;
    b_fits  = last_in && (b_total <= FULL);
    b_keep  = b_fits ? msb_mask(b_total) : '1;
    b_data  = (res_q | (data_in >> {res_cnt_q, 3'b000})) & byte_mask(b_keep);
    b_rcnt  = b_fits ? '0 : b_total - FULL;
    b_res   = (data_in << {FULL - res_cnt_q, 3'b000}) & byte_mask(msb_mask(b_rcnt));
    out_free = !valid_out_q || ready_out;
    case (state_q)
      FIRST:   ready_in = !valid_header_q || ready_header;
      BODY:    ready_in = out_free;
      default: ready_in = 1'b0;
    endcase
    accept = valid_in && ready_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FIRST;
      res_q          <= '0;
      res_cnt_q      <= '0;
      valid_out_q    <= 1'b0;
      last_out_q     <= 1'b0;
      data_out_q     <= '0;
      keep_out_q     <= '0;
      valid_header_q <= 1'b0;
      header_q       <= '0;
      keep_header_q  <= '0;
    end else begin
      if (valid_header_q && ready_header) valid_header_q <= 1'b0;
      if (valid_out_q && ready_out)       valid_out_q    <= 1'b0;
      case (state_q)
        FIRST: if (accept) begin
          header_q       <= f_hdata;
          keep_header_q  <= f_hkeep;
          valid_header_q <= 1'b1;
          res_q          <= f_res;
          res_cnt_q      <= f_rcnt;
          if (!last_in)           state_q <= BODY;
          else if (f_rcnt != '0)  state_q <= FLUSH;
          else                    state_q <= FIRST;
        end
        BODY: if (accept) begin
          data_out_q  <= b_data;
          keep_out_q  <= b_keep;
          last_out_q  <= b_fits;
          valid_out_q <= 1'b1;
          res_q       <= b_res;
          res_cnt_q   <= b_rcnt;
          if (b_fits)       state_q <= FIRST;
          else if (last_in) state_q <= FLUSH;
        end
        default: if (out_free) begin
          data_out_q  <= res_q & byte_mask(msb_mask(res_cnt_q));
          keep_out_q  <= msb_mask(res_cnt_q);
          last_out_q  <= 1'b1;
          valid_out_q <= 1'b1;
          res_q       <= '0;
          res_cnt_q   <= '0;
          state_q     <= FIRST;
        end
      endcase
    end
  end

  assign valid_out    = valid_out_q;
  assign data_out     = data_out_q;
  assign keep_out     = keep_out_q;
  assign last_out     = last_out_q;
  assign valid_header = valid_header_q;
  assign header_out   = header_q;
  assign keep_header  = keep_header_q;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Directed bench for axi_stream_extract_header: a byte-level packet model feeds
// expected header/payload queues that a single compare process checks.
module tb_axi_stream_extract_header;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int HW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in, last_in, ready_in;
  logic [DW-1:0] data_in;
  logic [BW-1:0] keep_in;
  logic [HW-1:0] hdr_len;
  logic          valid_out, last_out, ready_out;
  logic [DW-1:0] data_out;
  logic [BW-1:0] keep_out;
  logic          valid_header, ready_header;
  logic [DW-1:0] header_out;
  logic [BW-1:0] keep_header;

  always #5 clk = ~clk;

  axi_stream_extract_header #(.DATA_WD(DW), .DATA_BYTE_WD(BW), .HDR_LEN_WD(HW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in), .hdr_len(hdr_len),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_header(valid_header), .header_out(header_out), .keep_header(keep_header),
    .ready_header(ready_header)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_pay[$];
  beat_t       exp_hdr[$];
  logic [31:0] pkt[$];
  logic [3:0]  pkt_lk;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte-level model: flatten valid bytes, first min(h,len) form the header,
  // the rest is chopped into 4-byte MSB-first beats.
  task automatic model_packet(input int hl);
    byte unsigned b[$];
    logic [31:0]  w;
    logic [3:0]   k;
    beat_t        e;
    int           h, hn, len;
    for (int i = 0; i < pkt.size(); i++) begin
      w = pkt[i];
      k = (i == pkt.size() - 1) ? pkt_lk : 4'hF;
      for (int j = 0; j < 4; j++) if (k[3-j]) b.push_back(w[31-8*j -: 8]);
    end
    h   = (hl == 0 || hl > 4) ? 4 : hl;
    len = b.size();
    hn  = (len < h) ? len : h;
    e.d = '0; e.k = '0; e.l = 1'b0;
    for (int i = 0; i < hn; i++) begin
      e.d = {e.d[23:0], b[i]};
      e.k = {e.k[2:0], 1'b1};
    end
    exp_hdr.push_back(e);
    for (int p = hn; p < len; p += 4) begin
      e.d = '0; e.k = '0;
      for (int j = 0; j < 4; j++)
        if (p + j < len) begin
          e.d[31-8*j -: 8] = b[p+j];
          e.k[3-j] = 1'b1;
        end
      e.l = (p + 4 >= len);
      exp_pay.push_back(e);
    end
  endtask

  task automatic send_packet(input logic [2:0] hl, input int n_send);
    int t;
    for (int i = 0; i < n_send; i++) begin
      valid_in = 1'b1;
      data_in  = pkt[i];
      last_in  = (i == pkt.size() - 1);
      keep_in  = last_in ? pkt_lk : 4'hF;
      hdr_len  = hl;
      t = 0;
      forever begin
        @(negedge clk);
        if (ready_in) break;
        t++;
        if (t >= 200) break;
      end
      if (t >= 200) begin
        n_checks++; n_fail++;
        $display("FAIL ready_in_wait: got ready_in=0 for %0d cycles expected 1", t);
        break;
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0; last_in = 1'b0; data_in = '0; keep_in = '0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (exp_pay.size() == 0 && exp_hdr.size() == 0) break;
    end
    @(posedge clk); #1;
    check("pay_drained", exp_pay.size(), 0);
    check("hdr_drained", exp_hdr.size(), 0);
  endtask

  task automatic set_stream();
    pkt.delete();
    pkt.push_back(32'hAABBCCDD); pkt.push_back(32'hEEFF0011); pkt.push_back(32'h22334455);
    pkt.push_back(32'h66778899); pkt.push_back(32'h00AABBCC);
    pkt_lk = 4'b1100;
  endtask

  // Compare process: every handshake against the model, plus hold-stability under backpressure.
  initial begin
    logic        hold_o, hold_h, pl;
    logic [31:0] pd, ph;
    logic [3:0]  pk, phk;
    beat_t       e;
    hold_o = 1'b0; hold_h = 1'b0;
    pd = '0; ph = '0; pk = '0; phk = '0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_o = 1'b0; hold_h = 1'b0;
      end else begin
        if (valid_in && !ready_in) stall_cnt++;
        if (hold_o) begin
          check("out_hold_valid", valid_out, 1);
          check("out_hold_beat", {data_out, keep_out, last_out}, {pd, pk, pl});
        end
        if (hold_h) check("hdr_hold", {valid_header, header_out, keep_header}, {1'b1, ph, phk});
        if (valid_out && ready_out) begin
          if (exp_pay.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL pay_extra: got beat %0h expected none", data_out);
          end else begin
            e = exp_pay.pop_front();
            check("pay_data", data_out, e.d);
            check("pay_keep", keep_out, e.k);
            check("pay_last", last_out, e.l);
          end
        end
        if (valid_header && ready_header) begin
          if (exp_hdr.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL hdr_extra: got header %0h expected none", header_out);
          end else begin
            e = exp_hdr.pop_front();
            check("hdr_data", header_out, e.d);
            check("hdr_keep", keep_header, e.k);
          end
        end
        hold_o = valid_out && !ready_out;
        hold_h = valid_header && !ready_header;
        pd = data_out; pk = keep_out; pl = last_out; ph = header_out; phk = keep_header;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    hdr_len = '0; ready_out = 1'b1; ready_header = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_valid_header", valid_header, 0);
    check("rst_last_out", last_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_keep_out", keep_out, 0);
    check("rst_header_out", header_out, 0);
    check("rst_keep_header", keep_header, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: hdr_len=3, residual absorbs last beat, no flush
    set_stream(); model_packet(3);
    check("m1_hdr", {exp_hdr[0].d, exp_hdr[0].k}, {32'h00AABBCC, 4'b0111});
    check("m1_cnt", exp_pay.size(), 4);
    check("m1_b0", exp_pay[0].d, 32'hDDEEFF00);
    check("m1_last", {exp_pay[3].d, exp_pay[3].k, exp_pay[3].l}, {32'h9900AA00, 4'b1110, 1'b1});
    stall_cnt = 0;
    send_packet(3, 5);
    check("s1_no_stall", stall_cnt, 0);
    drain();

    // 2: hdr_len=1, trailing flush beat
    set_stream(); model_packet(1);
    check("m2_hdr", {exp_hdr[0].d, exp_hdr[0].k}, {32'h000000AA, 4'b0001});
    check("m2_cnt", exp_pay.size(), 5);
    check("m2_b3", {exp_pay[3].d, exp_pay[3].k, exp_pay[3].l}, {32'h77889900, 4'b1111, 1'b0});
    check("m2_flush", {exp_pay[4].d, exp_pay[4].k, exp_pay[4].l}, {32'hAA000000, 4'b1000, 1'b1});
    send_packet(1, 5);
    drain();

    // 3: hdr_len=4, pass-through
    set_stream(); model_packet(4);
    check("m3_hdr", {exp_hdr[0].d, exp_hdr[0].k}, {32'hAABBCCDD, 4'b1111});
    check("m3_b0", exp_pay[0].d, 32'hEEFF0011);
    check("m3_last", {exp_pay[3].d, exp_pay[3].k, exp_pay[3].l}, {32'h00AA0000, 4'b1100, 1'b1});
    stall_cnt = 0;
    send_packet(4, 5);
    check("s3_no_stall", stall_cnt, 0);
    drain();

    // 4: payload backpressure mid-packet
    set_stream(); model_packet(3);
    fork
      send_packet(3, 5);
      begin
        repeat (2) @(posedge clk);
        #1 ready_out = 1'b0;
        @(negedge clk); @(negedge clk);
        check("s4_ready_in_low", ready_in, 0);
        check("s4_valid_out_held", valid_out, 1);
        repeat (2) @(posedge clk);
        #1 ready_out = 1'b1;
      end
    join
    drain();

    // 5: header backpressure stalls the next packet's first beat
    ready_header = 1'b0;
    pkt.delete(); pkt.push_back(32'h11223344); pkt.push_back(32'h55667788); pkt_lk = 4'b1100;
    model_packet(4);
    send_packet(4, 2);
    pkt.delete(); pkt.push_back(32'h99AABBCC); pkt.push_back(32'hDDEEFF01); pkt_lk = 4'b1110;
    model_packet(2);
    check("m5_hdr", {exp_hdr[1].d, exp_hdr[1].k}, {32'h000099AA, 4'b0011});
    fork
      send_packet(2, 2);
      begin
        repeat (3) begin
          @(negedge clk);
          check("s5_ready_in_low", ready_in, 0);
        end
        @(posedge clk);
        #1 ready_header = 1'b1;
      end
    join
    drain();

    // 6: reset mid-packet, then a clean packet with a flush
    set_stream(); model_packet(3);
    send_packet(3, 2);
    rst_n = 1'b0;
    #1;
    check("s6_valid_out", valid_out, 0);
    check("s6_valid_header", valid_header, 0);
    check("s6_out_zero", {data_out, keep_out, last_out}, 0);
    check("s6_hdr_zero", {header_out, keep_header}, 0);
    exp_pay.delete(); exp_hdr.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    pkt.delete(); pkt.push_back(32'hCAFEBABE); pkt.push_back(32'h12345678); pkt_lk = 4'b1110;
    model_packet(2);
    check("m6_flush", {exp_pay[1].d, exp_pay[1].k, exp_pay[1].l}, {32'h56000000, 4'b1000, 1'b1});
    send_packet(2, 2);
    drain();

    // 7: hdr_len out of range, and single-beat packets shorter than / equal to h
    pkt.delete(); pkt.push_back(32'h11223344); pkt.push_back(32'h55667788); pkt_lk = 4'b1111;
    model_packet(0);
    send_packet(0, 2);
    drain();
    model_packet(7);
    check("m7_hdr", {exp_hdr[0].d, exp_hdr[0].k}, {32'h11223344, 4'b1111});
    send_packet(7, 2);
    drain();
    pkt.delete(); pkt.push_back(32'h12345678); pkt_lk = 4'b1100;
    model_packet(3);
    check("m7_short", {exp_hdr[0].d, exp_hdr[0].k}, {32'h00001234, 4'b0011});
    check("m7_short_nopay", exp_pay.size(), 0);
    send_packet(3, 1);
    drain();
    model_packet(2);
    send_packet(2, 1);
    drain();

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
